posit_extract_pipe: RTL and testbench

- Pipelined, parametrised posit field extractor, generalised in width N and exponent size ES.
- Decodes one posit word per cycle into sign, regime, exponent, mantissa and special flags.
- Uses valid/ready handshakes on both sides with full backpressure.
- Sits between the operand source and the posit multiplier datapath.

---
 rtl/posit_extract_pipe_if.sv | 64 ++++++
 rtl/posit_extract_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_posit_extract_pipe.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/posit_extract_pipe_if.sv
// Handshake and field bus for posit_extract_pipe.
//
// Parameters:
//   N  - posit word width (8..32)
//   ES - exponent field width (0..N-5)
//   TW - tag width, present only when POSIT_EXTRACT_TAG_EN is defined
//
// Signals:
//   in_valid/in_ready/In            - input word handshake
//   out_valid/out_ready             - output handshake
//   Sign, InRemain, RegimeValue,
//   Exponent, Mantissa, zero, inf   - decoded fields
//   in_tag/out_tag                  - sideband tag (POSIT_EXTRACT_TAG_EN only)
//
// Modports: master = operand source + consumer side, slave = the extractor.
// With ES = 0 the Exponent bus is kept 1 bit wide and always reads 0.

interface posit_extract_pipe_if #(
    parameter int unsigned N  = 16,
    parameter int unsigned ES = 2
`ifdef POSIT_EXTRACT_TAG_EN
    ,
    parameter int unsigned TW = 4
`endif
);
    localparam int unsigned RS   = $clog2(N);
    localparam int unsigned MW   = N - 2 - ES;
    localparam int unsigned ExpW = (ES > 0) ? ES : 1;

    logic                in_valid;
    logic                in_ready;
    logic [N-1:0]        In;
    logic                out_valid;
    logic                out_ready;
    logic                Sign;
    logic [N-2:0]        InRemain;
    logic [RS+1:0]       RegimeValue;
    logic [ExpW-1:0]     Exponent;
    logic [MW-1:0]       Mantissa;
    logic                zero;
    logic                inf;
`ifdef POSIT_EXTRACT_TAG_EN
    logic [TW-1:0]       in_tag;
    logic [TW-1:0]       out_tag;
`endif

    modport master (
        output in_valid, In, out_ready,
`ifdef POSIT_EXTRACT_TAG_EN
        output in_tag,
        input  out_tag,
`endif
        input  in_ready, out_valid, Sign, InRemain, RegimeValue, Exponent, Mantissa, zero, inf
    );

    modport slave (
        input  in_valid, In, out_ready,
`ifdef POSIT_EXTRACT_TAG_EN
        input  in_tag,
        output out_tag,
`endif
        output in_ready, out_valid, Sign, InRemain, RegimeValue, Exponent, Mantissa, zero, inf
    );
endinterface

// File: rtl/posit_extract_pipe.sv
// Three-stage pipelined posit field extractor.
//
// Decodes one N-bit posit per cycle into sign, two's-complemented magnitude,
// signed regime k, exponent and mantissa (hidden bit included), plus zero/NaR
// flags. Valid/ready on both sides with full backpressure; up to three words
// are buffered (one per stage).
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - posit_extract_pipe_if.slave (handshakes, input word, output fields)
//
// Stages:
//   S1 - sign, zero/NaR flags, |In|
//   S2 - regime run length, k, shift amount
//   S3 - field alignment; these registers drive the outputs
//
// Optional: define POSIT_EXTRACT_TAG_EN to carry a TW-bit tag alongside each word.

module posit_extract_pipe #(
    parameter int unsigned N  = 16,
    parameter int unsigned ES = 2
`ifdef POSIT_EXTRACT_TAG_EN
    ,
    parameter int unsigned TW = 4
`endif
) (
    input logic                clk,
    input logic                rst_n,
    posit_extract_pipe_if.slave bus
);
    localparam int unsigned RS    = $clog2(N);
    localparam int unsigned MW    = N - 2 - ES;
    localparam int unsigned FracW = N - 3 - ES;
    localparam int unsigned ExpW  = (ES > 0) ? ES : 1;

    typedef logic [RS+1:0] k_t;
    typedef logic [RS-1:0] run_t;

    localparam run_t ShiftMax = run_t'(N - 1);

    // ---------------- handshake ----------------
    logic s1_valid, s2_valid, s3_valid;
    logic s1_free, s2_free, s3_free;

    // A stage can take new data when it is empty or its content moves on.
    assign s3_free = !s3_valid || bus.out_ready;
    assign s2_free = !s2_valid || s3_free;
    assign s1_free = !s1_valid || s2_free;

    assign bus.in_ready = s1_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            if (s1_free) s1_valid <= bus.in_valid;
            if (s2_free) s2_valid <= s1_valid;
            if (s3_free) s3_valid <= s2_valid;
        end
    end

    // ---------------- stage 1 ----------------
    logic [N-1:0] in_neg;
    logic [N-1:0] in_abs;
    logic         in_zero;
    logic         in_inf;

    assign in_neg  = ~bus.In + {{(N-1){1'b0}}, 1'b1};
    assign in_abs  = bus.In[N-1] ? in_neg : bus.In;
    assign in_zero = (bus.In == '0);
    assign in_inf  = (bus.In == {1'b1, {(N-1){1'b0}}});

    logic         s1_sign, s1_zero, s1_inf;
    logic [N-2:0] s1_abs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sign <= 1'b0;
            s1_zero <= 1'b0;
            s1_inf  <= 1'b0;
            s1_abs  <= '0;
        end else if (s1_free && bus.in_valid) begin
            s1_sign <= bus.In[N-1];
            s1_zero <= in_zero;
            s1_inf  <= in_inf;
            s1_abs  <= in_abs[N-2:0];
        end
    end

    // ---------------- stage 2 ----------------
    run_t run_len;
    logic run_done;
    k_t   k_next;
    run_t shift_next;

    // Length of the run of s1_abs[N-2] starting at the MSB; ends at the first
    // opposite bit or at bit 0.
    always_comb begin
        run_len  = '0;
        run_done = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!run_done) begin
                if (s1_abs[i] == s1_abs[N-2]) run_len = run_len + 1'b1;
                else                          run_done = 1'b1;
            end
        end
    end

    always_comb begin
        k_next     = s1_abs[N-2] ? (k_t'(run_len) - k_t'(1)) : (k_t'(0) - k_t'(run_len));
        // Regime bits plus terminator; a run that reaches bit 0 has no terminator.
        shift_next = (run_len == ShiftMax) ? ShiftMax : run_len + 1'b1;
    end

    logic         s2_sign, s2_zero, s2_inf;
    logic [N-2:0] s2_rem;
    k_t           s2_k;
    run_t         s2_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b0;
            s2_inf   <= 1'b0;
            s2_rem   <= '0;
            s2_k     <= '0;
            s2_shift <= '0;
        end else if (s2_free && s1_valid) begin
            s2_sign  <= s1_sign;
            s2_zero  <= s1_zero;
            s2_inf   <= s1_inf;
            s2_rem   <= s1_abs;
            s2_k     <= k_next;
            s2_shift <= shift_next;
        end
    end

    // ---------------- stage 3 ----------------
    logic [N-2:0]    shifted;
    logic [ExpW-1:0] exp_next;
    logic [MW-1:0]   mant_next;
    logic            special;
    logic            unused_shift_lsbs;

    assign shifted = s2_rem << s2_shift;
    assign special = s2_zero || s2_inf;

    if (ES > 0) begin : g_exp
        assign exp_next = shifted[N-2 -: ExpW];
    end else begin : g_no_exp
        assign exp_next = '0;
    end

    assign mant_next = {1'b1, shifted[N-2-ES -: FracW]};
    // The two lowest positions only ever hold shifted-in zeros.
    assign unused_shift_lsbs = ^{shifted[1:0], in_abs[N-1]};

    logic            s3_sign, s3_zero, s3_inf;
    logic [N-2:0]    s3_rem;
    k_t              s3_k;
    logic [ExpW-1:0] s3_exp;
    logic [MW-1:0]   s3_mant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_sign <= 1'b0;
            s3_zero <= 1'b0;
            s3_inf  <= 1'b0;
            s3_rem  <= '0;
            s3_k    <= '0;
            s3_exp  <= '0;
            s3_mant <= '0;
        end else if (s3_free && s2_valid) begin
            s3_sign <= s2_sign;
            s3_zero <= s2_zero;
            s3_inf  <= s2_inf;
            s3_rem  <= special ? '0 : s2_rem;
            s3_k    <= special ? '0 : s2_k;
            s3_exp  <= special ? '0 : exp_next;
            s3_mant <= special ? '0 : mant_next;
        end
    end

    assign bus.out_valid   = s3_valid;
    assign bus.Sign        = s3_sign;
    assign bus.InRemain    = s3_rem;
    assign bus.RegimeValue = s3_k;
    assign bus.Exponent    = s3_exp;
    assign bus.Mantissa    = s3_mant;
    assign bus.zero        = s3_zero;
    assign bus.inf         = s3_inf;

`ifdef POSIT_EXTRACT_TAG_EN
    logic [TW-1:0] s1_tag, s2_tag, s3_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_tag <= '0;
            s2_tag <= '0;
            s3_tag <= '0;
        end else begin
            if (s1_free && bus.in_valid) s1_tag <= bus.in_tag;
            if (s2_free && s1_valid)     s2_tag <= s1_tag;
            if (s3_free && s2_valid)     s3_tag <= s2_tag;
        end
    end

    assign bus.out_tag = s3_tag;
`endif

endmodule

// File: tb/tb_posit_extract_pipe.sv
// Self-checking bench for posit_extract_pipe (N = 16, ES = 2).
// Reference model decodes each posit with integer arithmetic; a queue of
// accepted words is compared in order against every emitted result.

module tb_posit_extract_pipe;
    localparam int unsigned N  = 16;
    localparam int unsigned ES = 2;
    localparam int unsigned RS = $clog2(N);
    localparam int unsigned MW = N - 2 - ES;
    localparam int unsigned FW = N - 3 - ES;
    localparam int unsigned KW = RS + 2;
    localparam int unsigned RW = N - 1;
`ifdef POSIT_EXTRACT_TAG_EN
    localparam int unsigned TW = 4;
`endif

    typedef struct packed {
        logic          sign;
        logic [RW-1:0] rem;
        logic [KW-1:0] k;
        logic [ES-1:0] ex;
        logic [MW-1:0] mant;
        logic          z;
        logic          nar;
    } fields_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

`ifdef POSIT_EXTRACT_TAG_EN
    posit_extract_pipe_if #(.N(N), .ES(ES), .TW(TW)) bus ();
    posit_extract_pipe #(.N(N), .ES(ES), .TW(TW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    logic [TW-1:0] tag_q[$];
`else
    posit_extract_pipe_if #(.N(N), .ES(ES)) bus ();
    posit_extract_pipe #(.N(N), .ES(ES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int emitted      = 0;
    logic [N-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Posit decode from first principles: magnitude, leading-run length via bit length.
    function automatic fields_t model(input logic [N-1:0] w);
        fields_t     f;
        int unsigned mask, a, rem, run, sh, v;
        int          k;
        f      = '0;
        f.sign = w[N-1];
        if (w == '0) begin
            f.z = 1'b1;
            return f;
        end
        if (w == {1'b1, {(N-1){1'b0}}}) begin
            f.nar = 1'b1;
            return f;
        end
        mask = (32'd1 << (N - 1)) - 1;
        a    = w[N-1] ? ((32'd1 << N) - 32'(w)) : 32'(w);
        rem  = a & mask;
        if (((rem >> (N - 2)) & 1) == 1) begin
            run = (N - 1) - $clog2((~rem & mask) + 1);
            k   = int'(run) - 1;
        end else begin
            run = (N - 1) - $clog2(rem + 1);
            k   = -int'(run);
        end
        sh     = (run + 1 > N - 1) ? N - 1 : run + 1;
        v      = (rem << sh) & mask;
        f.rem  = RW'(rem);
        f.k    = KW'(k);
        f.ex   = ES'(v >> (N - 1 - ES));
        f.mant = MW'((32'd1 << FW) | ((v >> 2) & ((32'd1 << FW) - 1)));
        return f;
    endfunction

    function automatic fields_t dut_fields();
        fields_t f;
        f.sign = bus.Sign;
        f.rem  = bus.InRemain;
        f.k    = bus.RegimeValue;
        f.ex   = bus.Exponent;
        f.mant = bus.Mantissa;
        f.z    = bus.zero;
        f.nar  = bus.inf;
        return f;
    endfunction

    task automatic compare_fields(input string pfx, input fields_t got, input fields_t exp);
        check_eq({pfx, ".sign"}, 64'(got.sign), 64'(exp.sign));
        check_eq({pfx, ".rem"},  64'(got.rem),  64'(exp.rem));
        check_eq({pfx, ".k"},    64'(got.k),    64'(exp.k));
        check_eq({pfx, ".exp"},  64'(got.ex),   64'(exp.ex));
        check_eq({pfx, ".mant"}, 64'(got.mant), 64'(exp.mant));
        check_eq({pfx, ".zero"}, 64'(got.z),    64'(exp.z));
        check_eq({pfx, ".inf"},  64'(got.nar),  64'(exp.nar));
    endtask

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    initial begin : monitor
        logic    stall_prev;
        fields_t held;
        logic [N-1:0] w;
        stall_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check_eq("hold.valid", 64'(bus.out_valid), 64'd1);
                    check_eq("hold.fields", 64'(dut_fields()), 64'(held));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("out.unexpected", 64'(exp_q.size()), 64'd1);
                    end else begin
                        w = exp_q.pop_front();
                        compare_fields("out", dut_fields(), model(w));
`ifdef POSIT_EXTRACT_TAG_EN
                        check_eq("out.tag", 64'(bus.out_tag), 64'(tag_q.pop_front()));
`endif
                    end
                    emitted++;
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(bus.In);
`ifdef POSIT_EXTRACT_TAG_EN
                    tag_q.push_back(bus.in_tag);
`endif
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                held       = dut_fields();
            end
        end
    end

    task automatic set_in(input logic vld, input logic [N-1:0] w);
        bus.in_valid = vld;
        bus.In       = w;
`ifdef POSIT_EXTRACT_TAG_EN
        bus.in_tag   = w[TW-1:0] ^ w[N-1:N-TW];
`endif
    endtask

    // One word through an empty pipe; checks latency and literal field values.
    task automatic directed(input string tag, input logic [N-1:0] w, input logic sgn,
                            input logic [RW-1:0] rem, input int k, input logic [ES-1:0] ex,
                            input logic [MW-1:0] mant, input logic z, input logic nar);
        fields_t e;
        int      n;
        bus.out_ready = 1'b1;
        set_in(1'b1, w);
        @(negedge clk);
        check_eq({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        set_in(1'b0, '0);
        n = 1;
        while (!bus.out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, ".latency"}, 64'(n), 64'd3);
        e.sign = sgn;
        e.rem  = rem;
        e.k    = KW'(k);
        e.ex   = ex;
        e.mant = mant;
        e.z    = z;
        e.nar  = nar;
        compare_fields(tag, dut_fields(), e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        set_in(1'b0, '0);
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid) && g < 20) begin
            @(posedge clk);
            #1;
            g++;
        end
        check_eq({tag, ".drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int acc, e0, guard;
        fields_t snap;
        set_in(1'b0, '0);
        bus.out_ready = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst.in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("rst.fields", 64'(dut_fields()), 64'd0);
`ifdef POSIT_EXTRACT_TAG_EN
        check_eq("rst.tag", 64'(bus.out_tag), 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed decode cases
        directed("d4000", 16'h4000, 1'b0, 15'h4000,   0, 2'b00, 12'h800, 1'b0, 1'b0);
        directed("d0000", 16'h0000, 1'b0, 15'h0000,   0, 2'b00, 12'h000, 1'b1, 1'b0);
        directed("d8000", 16'h8000, 1'b1, 15'h0000,   0, 2'b00, 12'h000, 1'b0, 1'b1);
        directed("dC000", 16'hC000, 1'b1, 15'h4000,   0, 2'b00, 12'h800, 1'b0, 1'b0);
        directed("d5A5A", 16'h5A5A, 1'b0, 15'h5A5A,   0, 2'b11, 12'hA5A, 1'b0, 1'b0);
        directed("d7FFF", 16'h7FFF, 1'b0, 15'h7FFF,  14, 2'b00, 12'h800, 1'b0, 1'b0);
        directed("d0001", 16'h0001, 1'b0, 15'h0001, -14, 2'b00, 12'h800, 1'b0, 1'b0);

        // Backpressure: five offers against a stalled consumer
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, N'((i + 1) * 16'h1357));
            @(negedge clk);
            if (bus.in_ready) acc++;
            @(posedge clk);
            #1;
        end
        set_in(1'b0, '0);
        check_eq("bp.accepted", 64'(acc), 64'd3);
        check_eq("bp.in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("bp.out_valid", 64'(bus.out_valid), 64'd1);
        snap = dut_fields();
        repeat (4) @(posedge clk);
        #1;
        check_eq("bp.stable", 64'(dut_fields()), 64'(snap));
        e0 = emitted;
        drain("bp");
        check_eq("bp.emitted", 64'(emitted - e0), 64'd3);

        // Reset with two words in flight
        bus.out_ready = 1'b0;
        set_in(1'b1, 16'h3C3C);
        @(posedge clk);
        #1;
        set_in(1'b1, 16'h6123);
        @(posedge clk);
        #1;
        set_in(1'b0, '0);
        @(posedge clk);
        #1;
        check_eq("mrst.pre_valid", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mrst.out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("mrst.fields", 64'(dut_fields()), 64'd0);
        exp_q.delete();
`ifdef POSIT_EXTRACT_TAG_EN
        tag_q.delete();
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        directed("mrst.next", 16'h5A5A, 1'b0, 15'h5A5A, 0, 2'b11, 12'hA5A, 1'b0, 1'b0);

        // Random traffic with random stalls
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 3) != 0, N'($urandom));
            bus.out_ready = $urandom_range(0, 3) != 0;
            @(posedge clk);
            #1;
        end
        drain("rand");

        // Exhaustive sweep
        bus.out_ready = 1'b1;
        for (int i = 0; i < (1 << N); i++) begin
            set_in(1'b1, N'(i));
            acc   = 0;
            guard = 0;
            while (acc == 0 && guard < 50) begin
                @(negedge clk);
                acc = int'(bus.in_ready);
                @(posedge clk);
                #1;
                guard++;
            end
            if (acc == 0) begin
                check_eq("sweep.accept", 64'(acc), 64'd1);
                break;
            end
        end
        drain("sweep");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
